// File: rtl/bus_xfer_ctrl.sv
// Registered bus source multiplexer with request/ready handshake, consumer hold,
// and optional two-beat (low then high half) transfer of double-width sources.
module bus_xfer_ctrl #(
  parameter int unsigned     DATA_W    = 8,
  parameter int unsigned     NSRC      = 8,
  parameter int unsigned     SEL_W     = 3,
  parameter logic [NSRC-1:0] WIDE_MASK = 8'h30
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NSRC*2*DATA_W-1:0]   src_data,
  input  logic                       req,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       split,
  output logic                       ready,
  input  logic                       bus_hold,
  output logic [DATA_W-1:0]          busout,
  output logic                       bus_valid,
  output logic                       bus_last,
  output logic [SEL_W-1:0]           bus_src,
  output logic                       bus_err
);

  localparam int unsigned WordW = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StFirst, StLast} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   busout_q;
  logic [DATA_W-1:0]   hi_q;
  logic                valid_q;
  logic                last_q;
  logic                err_q;
  logic [SEL_W-1:0]    src_q;

  logic [WordW-1:0]    word_sel;
  logic                sel_ok;
  logic                sel_wide;

  // Out-of-range selects fall through with sel_ok=0 and a zero word.
  always_comb begin
    word_sel = '0;
    sel_ok   = 1'b0;
    sel_wide = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        word_sel = src_data[i*WordW +: WordW];
        sel_ok   = 1'b1;
        sel_wide = WIDE_MASK[i];
      end
    end
  end

  assign ready = (state_q == StIdle) || ((state_q == StLast) && !bus_hold);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      busout_q <= '0;
      hi_q     <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      src_q    <= '0;
    end else if (ready) begin
      if (req) begin
        valid_q <= 1'b1;
        src_q   <= sel;
        err_q   <= !sel_ok;
        hi_q    <= word_sel[WordW-1:DATA_W];
        // word_sel is zero for a bad select, so the error beat carries 0.
        busout_q <= word_sel[DATA_W-1:0];
        if (sel_ok && sel_wide && split) begin
          state_q <= StFirst;
          last_q  <= 1'b0;
        end else begin
          state_q <= StLast;
          last_q  <= 1'b1;
        end
      end else begin
        state_q  <= StIdle;
        busout_q <= '0;
        valid_q  <= 1'b0;
        last_q   <= 1'b0;
        err_q    <= 1'b0;
      end
    end else if ((state_q == StFirst) && !bus_hold) begin
      state_q  <= StLast;
      busout_q <= hi_q;
      last_q   <= 1'b1;
    end
  end

  assign busout    = busout_q;
  assign bus_valid = valid_q;
  assign bus_last  = last_q;
  assign bus_src   = src_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed test-plan steps plus random traffic checked
// against a queue-of-beats reference model.
module tb_bus_xfer_ctrl;

  localparam int DW = 8;
  localparam int NS = 7;
  localparam int SW = 3;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NS*2*DW-1:0]   src_data;
  logic                 req;
  logic [SW-1:0]        sel;
  logic                 split;
  logic                 ready;
  logic                 bus_hold;
  logic [DW-1:0]        busout;
  logic                 bus_valid;
  logic                 bus_last;
  logic [SW-1:0]        bus_src;
  logic                 bus_err;

  logic [15:0] src [NS];

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [2:0] s;
    logic       err;
  } beat_t;

  beat_t q[$];
  int errors = 0;
  int checks = 0;

  bus_xfer_ctrl #(
    .DATA_W   (DW),
    .NSRC     (NS),
    .SEL_W    (SW),
    .WIDE_MASK(7'h30)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .src_data (src_data),
    .req      (req),
    .sel      (sel),
    .split    (split),
    .ready    (ready),
    .bus_hold (bus_hold),
    .busout   (busout),
    .bus_valid(bus_valid),
    .bus_last (bus_last),
    .bus_src  (bus_src),
    .bus_err  (bus_err)
  );

  always #5 clock = ~clock;

  always_comb begin
    src_data = '0;
    for (int i = 0; i < NS; i++) src_data[i*16 +: 16] = src[i];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sources 4 and 5 are double width; a split request on them yields two beats.
  task automatic model_accept(input logic [2:0] s, input logic sp);
    logic [15:0] w;
    if (int'(s) >= NS) begin
      q.push_back(beat_t'{d: 8'h00, last: 1'b1, s: s, err: 1'b1});
    end else begin
      w = src[s];
      if ((s == 3'd4 || s == 3'd5) && sp) begin
        q.push_back(beat_t'{d: w[7:0],  last: 1'b0, s: s, err: 1'b0});
        q.push_back(beat_t'{d: w[15:8], last: 1'b1, s: s, err: 1'b0});
      end else begin
        q.push_back(beat_t'{d: w[7:0], last: 1'b1, s: s, err: 1'b0});
      end
    end
  endtask

  task automatic check_outputs();
    if (q.size() == 0) begin
      check("valid", bus_valid, 1'b0);
      check("busout", busout, 8'h00);
      check("last", bus_last, 1'b0);
      check("err", bus_err, 1'b0);
    end else begin
      check("valid", bus_valid, 1'b1);
      check("busout", busout, q[0].d);
      check("last", bus_last, q[0].last);
      check("err", bus_err, q[0].err);
      check("src", bus_src, q[0].s);
    end
  endtask

  function automatic logic model_ready(input logic h);
    return (q.size() == 0) || (q.size() == 1 && !h);
  endfunction

  task automatic step(input logic r, input logic [2:0] s, input logic sp, input logic h);
    logic exp_rdy;
    req = r; sel = s; split = sp; bus_hold = h;
    #1;
    exp_rdy = model_ready(h);
    check("ready", ready, exp_rdy);
    @(posedge clock);
    if (q.size() > 0 && !h) q.delete(0);
    if (r && exp_rdy) model_accept(s, sp);
    #1;
    check_outputs();
  endtask

  initial begin
    logic       r, sp, h, pend;
    logic [2:0] s;

    reset = 1'b1; req = 1'b0; sel = '0; split = 1'b0; bus_hold = 1'b0;
    for (int i = 0; i < NS; i++) src[i] = 16'(i * 16'h1111);
    #2;
    check("rst_ready", ready, 1'b1);
    check("rst_src", bus_src, 3'd0);
    check_outputs();
    #5 reset = 1'b0;

    // Single narrow transfer.
    src[1] = 16'h00A5;
    step(1'b1, 3'd1, 1'b0, 1'b0);
    check("t1_data", busout, 8'hA5);
    check("t1_last", bus_last, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    check("t1_idle", bus_valid, 1'b0);

    // Two-beat wide transfer, source altered after accept.
    src[5] = 16'hBEEF;
    step(1'b1, 3'd5, 1'b1, 1'b0);
    check("t2_lo", busout, 8'hEF);
    check("t2_lo_last", bus_last, 1'b0);
    check("t2_rdy", ready, 1'b0);
    src[5] = 16'h1234;
    step(1'b0, 3'd0, 1'b0, 1'b0);
    check("t2_hi", busout, 8'hBE);
    check("t2_hi_last", bus_last, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b0);

    // Back-to-back with a 3-cycle hold on the sel 2 beat.
    src[0] = 16'h0011; src[2] = 16'h0022; src[6] = 16'h0066;
    step(1'b1, 3'd0, 1'b0, 1'b0);
    check("t3_b0", busout, 8'h11);
    step(1'b1, 3'd2, 1'b0, 1'b0);
    check("t3_b2", busout, 8'h22);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd6, 1'b0, 1'b1);
      check("t3_held", busout, 8'h22);
    end
    step(1'b1, 3'd6, 1'b0, 1'b0);
    check("t3_b6", busout, 8'h66);
    step(1'b0, 3'd0, 1'b0, 1'b0);

    // Error select and unsplit wide source.
    step(1'b1, 3'd7, 1'b0, 1'b0);
    check("t4_err", bus_err, 1'b1);
    check("t4_data", busout, 8'h00);
    src[4] = 16'hCAFE;
    step(1'b1, 3'd4, 1'b0, 1'b0);
    check("t4_wide_lo", busout, 8'hFE);
    check("t4_wide_last", bus_last, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges during the low beat.
    src[5] = 16'hBEEF;
    step(1'b1, 3'd5, 1'b1, 1'b0);
    req = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("t5_busout", busout, 8'h00);
    check("t5_valid", bus_valid, 1'b0);
    check("t5_ready", ready, 1'b1);
    q.delete();
    #2 reset = 1'b0;
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b0, 1'b0);
    check("t5_after", busout, 8'h66);
    step(1'b0, 3'd0, 1'b0, 1'b0);

    // Random traffic; req/sel/split stay stable until accepted.
    pend = 1'b0; r = 1'b0; s = '0; sp = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pend) begin
        r  = ($urandom_range(0, 2) != 0);
        s  = 3'($urandom_range(0, 7));
        sp = 1'($urandom_range(0, 1));
      end
      h = ($urandom_range(0, 3) == 0);
      src[$urandom_range(0, NS - 1)] = 16'($urandom);
      pend = r && !model_ready(h);
      step(r, s, sp, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
